// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit feeding the register file write port.
// Multiplies use shift-add and divides use restoring division on operand magnitudes,
// one radix-2 step per clock, with the sign fixed up when the result is captured.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies are computed combinationally at
// the accept edge and complete in one cycle; divides keep the iterative path.

module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            wr_en,
    output logic [4:0]      wr_addr
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0]  SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Latched operation context and the shared iteration registers.
    // acc_hi/acc_lo hold {partial product, multiplier} for multiplies and
    // {partial remainder, dividend/quotient} for divides; op_mag is the
    // multiplicand or divisor magnitude.
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] op_mag;
    logic            neg_res;
    logic            neg_rem;
    logic [CNT_W-1:0] count;

    // Request decode on the live inputs
    logic            req_is_div;
    logic            req_a_signed;
    logic            req_b_signed;
    logic            req_a_neg;
    logic            req_b_neg;
    logic [XLEN-1:0] req_mag_a;
    logic [XLEN-1:0] req_mag_b;
    logic            req_div_zero;
    logic            req_overflow;
    logic            req_special;
    logic [XLEN-1:0] special_result;

    // Optional single-cycle multiply path
    logic            fast_hit;
    logic [XLEN-1:0] fast_result;

    // One radix-2 step
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] next_hi;
    logic [XLEN-1:0] next_lo;

    // Sign fix-up of the values produced by the final step
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_result;

    // Classify the incoming request: signedness, magnitudes and the divide special cases
    always_comb begin
        req_is_div     = funct3[2];
        req_a_signed   = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                         (funct3 == F_DIV)  || (funct3 == F_REM);
        req_b_signed   = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        req_a_neg      = req_a_signed && op_a[XLEN-1];
        req_b_neg      = req_b_signed && op_b[XLEN-1];
        req_mag_a      = req_a_neg ? (~op_a + 1'b1) : op_a;
        req_mag_b      = req_b_neg ? (~op_b + 1'b1) : op_b;
        req_div_zero   = req_is_div && (op_b == '0);
        req_overflow   = req_is_div && !funct3[0] &&
                         (op_a == SIGNED_MIN) && (op_b == '1);
        req_special    = req_div_zero || req_overflow;
        special_result = '0;
        if (req_div_zero) begin
            special_result = funct3[1] ? op_a : '1;
        end else if (req_overflow) begin
            special_result = funct3[1] ? '0 : SIGNED_MIN;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_ea;
    logic [2*XLEN-1:0] fast_eb;
    logic [2*XLEN-1:0] fast_prod;

    // Full-width product of the sign/zero-extended operands; the low 2*XLEN bits are exact
    always_comb begin
        fast_ea     = {{XLEN{req_a_neg}}, op_a};
        fast_eb     = {{XLEN{req_b_neg}}, op_b};
        fast_prod   = fast_ea * fast_eb;
        fast_hit    = !funct3[2];
        fast_result = (funct3 == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    // Without the fast path every multiply takes the iterative route
    always_comb begin
        fast_hit    = 1'b0;
        fast_result = '0;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and the state-derived handshake outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_special || fast_hit) begin
                        next_state = DONE;
                    end else begin
                        next_state = CALC;
                    end
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == LAST_ITER) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                wr_en      = (wr_addr != 5'd0);
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One shift-add or restoring-subtract step on the shared accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, op_mag};
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, op_mag};
        next_hi   = acc_hi;
        next_lo   = acc_lo;
        if (funct3_q[2]) begin
            if (!div_diff[XLEN]) begin
                next_hi = div_diff[XLEN-1:0];
                next_lo = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                next_hi = div_shift[XLEN-1:0];
                next_lo = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_lo[0]) begin
                next_hi = mul_sum[XLEN:1];
                next_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
            end else begin
                next_hi = {1'b0, acc_hi[XLEN-1:1]};
                next_lo = {acc_hi[0], acc_lo[XLEN-1:1]};
            end
        end
    end

    // Apply the stored signs to the last step's outputs and pick the requested word
    always_comb begin
        prod         = {next_hi, next_lo};
        prod_signed  = neg_res ? (~prod + 1'b1) : prod;
        quo          = neg_res ? (~next_lo + 1'b1) : next_lo;
        rem          = neg_rem ? (~next_hi + 1'b1) : next_hi;
        final_result = prod_signed[2*XLEN-1:XLEN];
        if (funct3_q[2]) begin
            final_result = funct3_q[1] ? rem : quo;
        end else if (funct3_q[1:0] == 2'b00) begin
            final_result = prod_signed[XLEN-1:0];
        end
    end

    // Operand capture on accept, iteration updates in CALC, result capture on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= '0;
            wr_addr  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            op_mag   <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            count    <= '0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        funct3_q <= funct3;
                        wr_addr  <= rd_addr;
                        count    <= '0;
                        acc_hi   <= '0;
                        neg_res  <= req_a_neg ^ req_b_neg;
                        neg_rem  <= req_a_neg;
                        if (req_is_div) begin
                            acc_lo <= req_mag_a;
                            op_mag <= req_mag_b;
                        end else begin
                            acc_lo <= req_mag_b;
                            op_mag <= req_mag_a;
                        end
                        if (req_special) begin
                            result <= special_result;
                        end else if (fast_hit) begin
                            result <= fast_result;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    count  <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        result <= final_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
